inst_fetch_ctrl: RTL
====================

// Module: inst_fetch_ctrl
//
// PURPOSE
// - Fetch sequencer for the RV32I core: owns the program counter and drives the
//   word-indexed combinational instruction ROM address.
// - Registers each fetched word, with its PC, into an output stage that uses a
//   valid/ready handshake toward decode.
// - Supports start, branch/jump redirect, end-of-ROM halt and a retired-fetch counter.
// - Sits between the instruction ROM and the decode/register-file stage.
//
// PARAMETERS
// P_RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
// P_ROM_DEPTH  64             ROM size in 32-bit words; end address = P_ROM_DEPTH*4
// P_CNT_W      16             width of oInstCnt
//
// PORTS
// iClk         in   1        clock, rising edge
// iRst         in   1        reset; synchronous, active-high
// iStart       in   1        single-cycle pulse; leaves IDLE
// iRedirect    in   1        branch/jump taken; flushes the output stage
// iRedirectPc  in   32       redirect target; bits [1:0] ignored and forced to 00
// oRomAddr     out  32       byte address to the ROM (ROM indexes [31:2])
// iRomData     in   32       ROM read data, combinational from oRomAddr
// oInstValid   out  1        oInst/oPc hold a valid instruction
// iInstReady   in   1        decode accepts the instruction this cycle
// oInst        out  32       registered instruction word
// oPc          out  32       byte address of oInst
// oHalted      out  1        1 while in HALT
// oInstCnt     out  P_CNT_W  handshakes completed; saturates at all-ones
//
// BEHAVIOUR
// - FSM states: IDLE, RUN, HALT.
//   - Reset -> IDLE.
//   - IDLE -> RUN on iStart.
//   - RUN -> HALT when a load consumes the last word (rPc == P_ROM_DEPTH*4-4).
//   - RUN or HALT -> RUN on iRedirect, unless the target is >= P_ROM_DEPTH*4;
//     then the next state is HALT.
//   - iStart is ignored outside IDLE.
// - Reset values:
//   - rPc = P_RESET_PC, so oRomAddr = P_RESET_PC.
//   - oInstValid = 0, oInst = 0, oPc = 0, oHalted = 0, oInstCnt = 0.
// - oRomAddr = rPc at all times (combinational from the PC register).
// - load = (state==RUN) && !iRedirect && (!oInstValid || iInstReady).
//   - On load: oInst <= iRomData, oPc <= rPc, oInstValid <= 1, rPc <= rPc+4.
// - Handshake = oInstValid && iInstReady && !iRedirect.
//   - A handshake with no simultaneous load clears oInstValid.
// - oInst/oPc/oInstValid stay stable while oInstValid=1 and iInstReady=0.
// - Throughput: 1 instruction/cycle with iInstReady held 1.
//   - Latency: iStart sampled at edge N -> oInstValid=1 after edge N+1.
// - Redirect has the highest priority:
//   - oInstValid <= 0; the held instruction is discarded and not counted,
//     even if iInstReady=1.
//   - rPc <= {iRedirectPc[31:2],2'b00}; the first new instruction is valid
//     2 edges after the redirect edge.
//   - In IDLE a redirect only updates rPc; the state stays IDLE.
// - HALT:
//   - No loads; a pending oInstValid stays until accepted (the last word is delivered).
//   - oHalted = 1; only iRedirect or iRst leaves HALT.
// - oInstCnt += 1 per handshake; holds at 2^P_CNT_W-1.
// - iRst mid-operation: all state returns to reset values at that edge;
//   an in-flight instruction is dropped.
// - PC arithmetic is 32-bit unsigned; no wrap past P_ROM_DEPTH*4 (HALT first).
//
// TESTING
// - Reset, iStart at cycle 1, ready=1:
//   -> oPc = 0,4,8,... on consecutive cycles; oInst matches ROM words 0,1,2;
//      oInstCnt increments every cycle.
// - Backpressure: ready=0 for 3 cycles while valid, oPc=8
//   -> oInst/oPc held at 8; rPc=12; the next fetch resumes at 12 with no skip
//      and no duplicate.
// - Redirect to 0x22 while valid with oPc=4 and ready=1
//   -> oPc=4 not counted; next valid has oPc=0x20, 2 edges later.
// - Run to end with P_ROM_DEPTH=4
//   -> oPc 0,4,8,C delivered; oHalted=1; no further valid; count=4;
//      redirect to 0 -> RUN, oPc=0 again.
// - Redirect to 0x100 (>= end)
//   -> HALT immediately; oInstValid=0.
// - iRst asserted while valid with ready=0
//   -> next cycle oInstValid=0, oRomAddr=P_RESET_PC, IDLE; iStart is required to refetch.
// - Counter saturation with P_CNT_W=2: 5 handshakes -> oInstCnt=3.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - RV32I fetch sequencer: PC, ROM addressing, valid/ready output stage
// Redirect outranks every other event; HALT is entered before the PC can run past the ROM.
module inst_fetch_ctrl #(
  parameter logic [31:0] P_RESET_PC  = 32'h0000_0000,
  parameter int          P_ROM_DEPTH = 64,
  parameter int          P_CNT_W     = 16
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iStart,
  input  logic               iRedirect,
  input  logic [31:0]        iRedirectPc,
  output logic [31:0]        oRomAddr,
  input  logic [31:0]        iRomData,
  output logic               oInstValid,
  input  logic               iInstReady,
  output logic [31:0]        oInst,
  output logic [31:0]        oPc,
  output logic               oHalted,
  output logic [P_CNT_W-1:0] oInstCnt
);

  localparam logic [31:0] END_ADDR  = 32'(P_ROM_DEPTH * 4);
  localparam logic [31:0] LAST_ADDR = END_ADDR - 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] redirect_pc;
  logic        redirect_oob;
  logic        load;
  logic        handshake;

  assign redirect_pc  = iRedirectPc & 32'hFFFF_FFFC;
  assign redirect_oob = (redirect_pc >= END_ADDR);
  assign handshake    = oInstValid && iInstReady && !iRedirect;
  assign oRomAddr     = pc_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (iStart) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN, S_HALT: begin
        if (iRedirect) begin
          state_nxt = redirect_oob ? S_HALT : S_RUN;
        end else if (load && (pc_q == LAST_ADDR)) begin
          state_nxt = S_HALT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load    = (state == S_RUN) && !iRedirect && (!oInstValid || iInstReady);
    oHalted = (state == S_HALT);
  end

  // A redirect discards the held word; otherwise a load refills the stage in the
  // same cycle the old word is accepted, so the stage only empties without a load.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pc_q       <= P_RESET_PC;
      oInstValid <= 1'b0;
      oInst      <= 32'd0;
      oPc        <= 32'd0;
      oInstCnt   <= '0;
    end else begin
      if (iRedirect) begin
        pc_q       <= redirect_pc;
        oInstValid <= 1'b0;
      end else if (load) begin
        oInst      <= iRomData;
        oPc        <= pc_q;
        oInstValid <= 1'b1;
        pc_q       <= pc_q + 32'd4;
      end else if (handshake) begin
        oInstValid <= 1'b0;
      end
      if (handshake && !(&oInstCnt)) begin
        oInstCnt <= oInstCnt + P_CNT_W'(1);
      end
    end
  end

endmodule
